// File: rtl/corr_sweep_pkg.sv
// Shared definitions for the correlation sweep controller and the correlation-score stage.
// Covers coordinate and score widths, FSM state codes and the default sweep limits.
package corr_sweep_pkg;

    localparam int COORD_W   = 13;
    localparam int SCORE_W   = 16;
    localparam int DEF_X_MAX = 16;
    localparam int DEF_Y_MAX = 16;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [SCORE_W-1:0] score_t;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_ARM     = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_COMPARE = 3'd4;
    localparam logic [2:0] S_ADVANCE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    // One extra bit so a step past the 13-bit range is still visible to the limit compare.
    function automatic logic [COORD_W:0] stepCoord(input coord_t c, input int unsigned stp);
        logic [31:0] stpVec;
        stpVec = stp;
        return {1'b0, c} + stpVec[COORD_W:0];
    endfunction

endpackage

// File: rtl/corr_raster_cnt.sv
// Raster start-position generator: X is the inner loop, Y the outer loop.
// lastX/lastY flag that the next step would pass the respective limit.
module corr_raster_cnt
    import corr_sweep_pkg::*;
#(
    parameter int X_MAX = DEF_X_MAX,
    parameter int Y_MAX = DEF_Y_MAX,
    parameter int STEP  = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   step,
    output coord_t X,
    output coord_t Y,
    output logic   lastX,
    output logic   lastY
);

    localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(X_MAX);
    localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(Y_MAX);

    logic [COORD_W:0] nextX;
    logic [COORD_W:0] nextY;

    assign nextX = stepCoord(X, STEP);
    assign nextY = stepCoord(Y, STEP);
    assign lastX = nextX > X_LIM;
    assign lastY = nextY > Y_LIM;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            X <= '0;
            Y <= '0;
        end else if (step) begin
            if (lastX) begin
                X <= '0;
                Y <= nextY[COORD_W-1:0];
            end else begin
                X <= nextX[COORD_W-1:0];
            end
        end
    end

endmodule

// File: rtl/corr_sweep.sv
// Sweeps correlation start positions over a raster, launching one correlation per
// position and keeping the best score, with a per-position timeout.
module corr_sweep
    import corr_sweep_pkg::*;
#(
    parameter int X_MAX   = DEF_X_MAX,
    parameter int Y_MAX   = DEF_Y_MAX,
    parameter int STEP    = 1,
    parameter int TIMEOUT = 65535
) (
    input  logic   iCLK,
    input  logic   iRST,
    input  logic   iStart,
    input  logic   iCorr_finished,
    input  score_t iCorr_score,
    output coord_t oXstart,
    output coord_t oYstart,
    output logic   oCorr_start,
    output logic   oBusy,
    output logic   oDone,
    output coord_t oBest_X,
    output coord_t oBest_Y,
    output score_t oBest_score,
    output logic   oTimeout
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] waitCnt;
    score_t           scoreHold;
    logic             bestValid;
    logic             rasterClear;
    logic             rasterStep;
    logic             lastX;
    logic             lastY;
    logic             waitExpired;

    assign rasterClear = (state == S_IDLE) && iStart;
    assign rasterStep  = (state == S_ADVANCE) && !(lastX && lastY);
    assign waitExpired = (waitCnt == CNT_LAST);

    assign oCorr_start = (state == S_LAUNCH);
    assign oBusy       = (state != S_IDLE) && (state != S_DONE);
    assign oDone       = (state == S_DONE);

    corr_raster_cnt #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX),
        .STEP  (STEP)
    ) uRaster (
        .clk   (iCLK),
        .rst   (iRST),
        .clear (rasterClear),
        .step  (rasterStep),
        .X     (oXstart),
        .Y     (oYstart),
        .lastX (lastX),
        .lastY (lastY)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= S_IDLE;
            waitCnt     <= '0;
            bestValid   <= 1'b0;
            oBest_X     <= '0;
            oBest_Y     <= '0;
            oBest_score <= '0;
            oTimeout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iStart) begin
                        state       <= S_LAUNCH;
                        bestValid   <= 1'b0;
                        oBest_X     <= '0;
                        oBest_Y     <= '0;
                        oBest_score <= '0;
                        oTimeout    <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    waitCnt <= '0;
                    state   <= S_ARM;
                end
                // Expiry is checked first here so the counter can never run past its last value.
                S_ARM: begin
                    waitCnt <= waitCnt + 1'b1;
                    if (waitExpired) begin
                        oTimeout <= 1'b1;
                        state    <= S_ADVANCE;
                    end else if (!iCorr_finished) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    waitCnt <= waitCnt + 1'b1;
                    if (iCorr_finished) begin
                        scoreHold <= iCorr_score;
                        state     <= S_COMPARE;
                    end else if (waitExpired) begin
                        oTimeout <= 1'b1;
                        state    <= S_ADVANCE;
                    end
                end
                S_COMPARE: begin
                    if (!bestValid || (scoreHold > oBest_score)) begin
                        bestValid   <= 1'b1;
                        oBest_X     <= oXstart;
                        oBest_Y     <= oYstart;
                        oBest_score <= scoreHold;
                    end
                    state <= S_ADVANCE;
                end
                S_ADVANCE: begin
                    state <= (lastX && lastY) ? S_DONE : S_LAUNCH;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_corr_sweep.sv
// Bench for corr_sweep: two instances (unit step 3x3 raster, step-3 raster) driven by a
// behavioural correlation-score stage; launches and best results checked via queues.
module tb_corr_sweep;

    typedef struct {
        int x;
        int y;
    } pos_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startS [2] = '{1'b0, 1'b0};
    logic        finS   [2] = '{1'b0, 1'b0};
    logic [15:0] scoreS [2] = '{16'd0, 16'd0};
    logic [12:0] xS [2];
    logic [12:0] yS [2];
    logic [12:0] bxS [2];
    logic [12:0] byS [2];
    logic [15:0] bsS [2];
    logic        csS [2];
    logic        busyS [2];
    logic        doneS [2];
    logic        toS [2];

    int   modeS   [2] = '{0, 0};
    int   phaseS  [2] = '{0, 0};
    int   doneCnt [2] = '{0, 0};
    int   curX    [2] = '{0, 0};
    int   curY    [2] = '{0, 0};
    logic activeS [2] = '{1'b0, 1'b0};

    pos_t expQ [$];
    pos_t obsQ [$];
    pos_t mp;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    corr_sweep #(.X_MAX(2), .Y_MAX(2), .STEP(1), .TIMEOUT(20)) dutA (
        .iCLK(clk), .iRST(rst), .iStart(startS[0]),
        .iCorr_finished(finS[0]), .iCorr_score(scoreS[0]),
        .oXstart(xS[0]), .oYstart(yS[0]), .oCorr_start(csS[0]),
        .oBusy(busyS[0]), .oDone(doneS[0]),
        .oBest_X(bxS[0]), .oBest_Y(byS[0]), .oBest_score(bsS[0]), .oTimeout(toS[0])
    );

    corr_sweep #(.X_MAX(7), .Y_MAX(7), .STEP(3), .TIMEOUT(20)) dutB (
        .iCLK(clk), .iRST(rst), .iStart(startS[1]),
        .iCorr_finished(finS[1]), .iCorr_score(scoreS[1]),
        .oXstart(xS[1]), .oYstart(yS[1]), .oCorr_start(csS[1]),
        .oBusy(busyS[1]), .oDone(doneS[1]),
        .oBest_X(bxS[1]), .oBest_Y(byS[1]), .oBest_score(bsS[1]), .oTimeout(toS[1])
    );

    function automatic int limOf(input int d);
        return (d == 0) ? 2 : 7;
    endfunction

    function automatic int stepOf(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Modes: 0 X+3Y, 1 tie, 2 stale finish, 3 hang at (1,1), 4 hang everywhere, 5 hang at (1,0)
    function automatic int scoreOf(input int mode, input int x, input int y);
        if (mode == 1) return ((x == 1 && y == 0) || (x == 0 && y == 1)) ? 100 : 50;
        if (mode == 3 && x == 1 && y == 1) return 999;
        if (mode == 5) return x + 3 * y + 7;
        return x + 3 * y;
    endfunction

    function automatic bit neverFin(input int mode, input int x, input int y);
        return (mode == 3 && x == 1 && y == 1) || (mode == 4) || (mode == 5 && x == 1 && y == 0);
    endfunction

    // Behavioural correlation-score stage, updated away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (csS[d]) begin
                curX[d]    = int'(xS[d]);
                curY[d]    = int'(yS[d]);
                phaseS[d]  = 0;
                activeS[d] = 1'b1;
                mp.x = curX[d];
                mp.y = curY[d];
                obsQ.push_back(mp);
                if (modeS[d] == 2) begin
                    finS[d]   = 1'b1;
                    scoreS[d] = 16'hFFFF;
                end else begin
                    finS[d] = 1'b0;
                end
            end else if (!busyS[d] && modeS[d] == 2) begin
                finS[d]   = 1'b1;
                scoreS[d] = 16'hFFFF;
            end else if (activeS[d]) begin
                phaseS[d]++;
            end
            if (activeS[d]) begin
                if (modeS[d] == 2 && phaseS[d] >= 2 && phaseS[d] <= 4) begin
                    finS[d] = 1'b0;
                end else if (phaseS[d] >= ((modeS[d] == 2) ? 5 : 2) &&
                             !neverFin(modeS[d], curX[d], curY[d])) begin
                    finS[d]    = 1'b1;
                    scoreS[d]  = 16'(scoreOf(modeS[d], curX[d], curY[d]));
                    activeS[d] = 1'b0;
                end
            end
            if (doneS[d]) doneCnt[d]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic runSweep(input int d, input int mode, input bit pokeMid, input bit pokeDone,
                            input string tag);
        int   bx, by, bs, dc0;
        bit   bv, tExp, got;
        pos_t p, q;
        expQ.delete();
        obsQ.delete();
        bv = 0; bx = 0; by = 0; bs = 0; tExp = 0;
        for (int y = 0; y <= limOf(d); y += stepOf(d)) begin
            for (int x = 0; x <= limOf(d); x += stepOf(d)) begin
                p.x = x;
                p.y = y;
                expQ.push_back(p);
                if (neverFin(mode, x, y)) begin
                    tExp = 1;
                end else if (!bv || scoreOf(mode, x, y) > bs) begin
                    bv = 1; bs = scoreOf(mode, x, y); bx = x; by = y;
                end
            end
        end
        modeS[d] = mode;
        dc0 = doneCnt[d];
        @(negedge clk);
        startS[d] = 1'b1;
        @(negedge clk);
        startS[d] = 1'b0;
        check({tag, "_busy"}, 32'(busyS[d]), 32'd1);
        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            startS[d] = pokeMid && (i == 15);
            if (doneS[d]) got = 1;
        end
        startS[d] = 1'b0;
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_bestX"}, 32'(bxS[d]), 32'(bx));
        check({tag, "_bestY"}, 32'(byS[d]), 32'(by));
        check({tag, "_bestScore"}, 32'(bsS[d]), 32'(bs));
        check({tag, "_timeout"}, 32'(toS[d]), 32'(tExp));
        check({tag, "_busyAtDone"}, 32'(busyS[d]), 32'd0);
        if (pokeDone) begin
            startS[d] = 1'b1;
            @(negedge clk);
            startS[d] = 1'b0;
            check({tag, "_startInDone"}, 32'({busyS[d], csS[d]}), 32'd0);
        end
        repeat (4) @(negedge clk);
        check({tag, "_idle"}, 32'(busyS[d]), 32'd0);
        check({tag, "_doneCount"}, 32'(doneCnt[d] - dc0), 32'd1);
        check({tag, "_launches"}, 32'(obsQ.size()), 32'(expQ.size()));
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            p = expQ.pop_front();
            q = obsQ.pop_front();
            check({tag, "_pos"}, 32'((q.x << 16) | q.y), 32'((p.x << 16) | p.y));
        end
    endtask

    initial begin : stim
        int  dc0;
        bit  got;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_coord", 32'({xS[d], yS[d]}), 32'd0);
            check("rst_best", 32'({bxS[d], byS[d]}), 32'd0);
            check("rst_score", 32'(bsS[d]), 32'd0);
            check("rst_flags", 32'({csS[d], busyS[d], doneS[d], toS[d]}), 32'd0);
        end

        runSweep(0, 0, 1'b0, 1'b1, "basic");
        runSweep(0, 1, 1'b0, 1'b0, "tie");
        runSweep(0, 2, 1'b0, 1'b0, "stale");
        runSweep(0, 3, 1'b0, 1'b0, "tmo");
        runSweep(0, 4, 1'b0, 1'b0, "alltmo");
        runSweep(0, 0, 1'b0, 1'b0, "afterTmo");

        // Reset while waiting on the position (1,0)
        modeS[0] = 5;
        expQ.delete();
        obsQ.delete();
        dc0 = doneCnt[0];
        @(negedge clk);
        startS[0] = 1'b1;
        @(negedge clk);
        startS[0] = 1'b0;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (obsQ.size() >= 2) got = 1;
        end
        check("rstmid_reach", 32'(got), 32'd1);
        repeat (4) @(negedge clk);
        check("rstmid_preBest", 32'(bsS[0]), 32'd7);
        check("rstmid_preBusy", 32'(busyS[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_coord", 32'({xS[0], yS[0]}), 32'd0);
        check("rstmid_best", 32'({bxS[0], byS[0]}), 32'd0);
        check("rstmid_score", 32'(bsS[0]), 32'd0);
        check("rstmid_flags", 32'({csS[0], busyS[0], doneS[0], toS[0]}), 32'd0);
        repeat (3) @(negedge clk);
        check("rstmid_noDone", 32'(doneCnt[0] - dc0), 32'd0);
        rst = 1'b1;
        startS[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        startS[0] = 1'b0;
        check("rstPrio_busy", 32'(busyS[0]), 32'd0);
        @(negedge clk);
        check("rstPrio_launch", 32'(csS[0]), 32'd0);
        runSweep(0, 0, 1'b0, 1'b0, "restart");

        runSweep(1, 0, 1'b1, 1'b1, "step3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
